// File: rtl/serial_link_pkg.sv
// Shared types and helpers for the single-wire strobe-qualified serial link.
package serial_link_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        if (n <= 1) begin
            return 1;
        end
        return int'($clog2(n));
    endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit period counter: counts 0..CLKS_PER_BIT-1 while running and flags the terminal tick.
module bit_tick_gen
    import serial_link_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int unsigned TW = clog2_min1(CLKS_PER_BIT);
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = run && (cnt_q == LAST);

endmodule

// File: rtl/serializer_tx.sv
// Parallel-to-serial transmitter: valid/ready word in, one bit per CLKS_PER_BIT cycles out on sd,
// with a one-cycle sd_en strobe in the last cycle of each bit.
module serializer_tx
    import serial_link_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter bit          MSB_FIRST    = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sd,
    output logic             sd_en,
    output logic             frame,
    output logic             done
);

    localparam int unsigned BW = clog2_min1(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             ready_q;
    logic             in_shift;
    logic             accept;
    logic             tick;
    logic             last_bit;
    logic             head;

    assign in_shift = (state_q == SHIFT);
    // ready_q stays low out of reset until the first edge, so no word is taken before then.
    assign accept   = load_valid && ready_q;
    assign last_bit = (bit_q == LAST_BIT);

    bit_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .clear(accept),
        .run  (in_shift),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bit_d   = bit_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    sr_d    = data_in;
                    bit_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    sr_d = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
                    if (last_bit) begin
                        state_d = IDLE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            bit_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            ready_q <= (state_d == IDLE);
        end
    end

    assign head       = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
    assign load_ready = ready_q;
    assign sd         = in_shift && head;
    assign sd_en      = tick;
    assign frame      = in_shift;
    assign done       = tick && last_bit;

endmodule

// File: tb/tb_serializer_tx.sv
// Scoreboard bench for serializer_tx: three configurations share one clock and reset.
module tb_serializer_tx;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] d0, d1, d2;
    logic       lv0, lv1, lv2;
    logic       rdy0, sd0, en0, fr0, dn0;
    logic       rdy1, sd1, en1, fr1, dn1;
    logic       rdy2, sd2, en2, fr2, dn2;

    serializer_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .MSB_FIRST(1'b1)) u0 (
        .clk(clk), .reset(reset), .data_in(d0), .load_valid(lv0), .load_ready(rdy0),
        .sd(sd0), .sd_en(en0), .frame(fr0), .done(dn0));
    serializer_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .MSB_FIRST(1'b0)) u1 (
        .clk(clk), .reset(reset), .data_in(d1), .load_valid(lv1), .load_ready(rdy1),
        .sd(sd1), .sd_en(en1), .frame(fr1), .done(dn1));
    serializer_tx #(.WIDTH(8), .CLKS_PER_BIT(3), .MSB_FIRST(1'b1)) u2 (
        .clk(clk), .reset(reset), .data_in(d2), .load_valid(lv2), .load_ready(rdy2),
        .sd(sd2), .sd_en(en2), .frame(fr2), .done(dn2));

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [7:0] q0[$], q1[$], q2[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic rdy_of(input int idx);
        case (idx)
            0:       return rdy0;
            1:       return rdy1;
            default: return rdy2;
        endcase
    endfunction

    function automatic int qsize(input int idx);
        case (idx)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    // Offer a word, wait for the accepting edge, and log the expected word.
    task automatic send(input int idx, input logic [7:0] w, input bit push, input bit hold,
                        output int acc_edge);
        bit got = 0;
        bit r;
        int c;
        int t = 0;
        acc_edge = -1;
        @(negedge clk);
        case (idx)
            0:       begin d0 = w; lv0 = 1'b1; end
            1:       begin d1 = w; lv1 = 1'b1; end
            default: begin d2 = w; lv2 = 1'b1; end
        endcase
        while (!got && t < 300) begin
            r = rdy_of(idx);
            c = cyc;
            @(posedge clk);
            if (r) begin
                got = 1;
                acc_edge = c + 1;
            end else begin
                @(negedge clk);
            end
            t++;
        end
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL send timeout dut%0d: got no acceptance, expected load_ready", idx);
        end else if (push) begin
            case (idx)
                0:       q0.push_back(w);
                1:       q1.push_back(w);
                default: q2.push_back(w);
            endcase
        end
        if (!hold) begin
            @(negedge clk);
            case (idx)
                0:       lv0 = 1'b0;
                1:       lv1 = 1'b0;
                default: lv2 = 1'b0;
            endcase
        end
    endtask

    task automatic wait_empty(input int idx);
        bit ok = 0;
        int t = 0;
        while (!ok && t < 600) begin
            @(negedge clk);
            if (qsize(idx) == 0) ok = 1;
            t++;
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain dut%0d: got %0d pending words, expected 0", idx, qsize(idx));
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor u0: MSB first, one cycle per bit.
    logic [7:0] acc0 = '0;
    int nb0 = 0, dc0 = 0, last_done0 = 0;
    initial forever begin
        @(negedge clk);
        if (reset) begin
            nb0 = 0;
            acc0 = '0;
        end else begin
            if (!fr0) chk("u0 idle outputs", {29'd0, sd0, en0, dn0}, 32'd0);
            if (en0) begin
                acc0 = {acc0[6:0], sd0};
                nb0++;
            end
            if (dn0) begin
                dc0++;
                last_done0 = cyc;
                chk("u0 done with strobe", {31'd0, en0}, 32'd1);
                chk("u0 strobes per word", nb0, 8);
                if (q0.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL u0 unexpected done: got word %h, expected no done", acc0);
                end else begin
                    chk("u0 word", {24'd0, acc0}, {24'd0, q0.pop_front()});
                end
                nb0 = 0;
            end
        end
    end

    // Monitor u1: LSB first, four cycles per bit, strobe in the last cycle.
    logic [7:0] acc1 = '0;
    int nb1 = 0, fc1 = 0;
    logic bitv1 = 1'b0;
    initial forever begin
        @(negedge clk);
        if (reset) begin
            nb1 = 0;
            fc1 = 0;
            acc1 = '0;
        end else if (fr1) begin
            if (fc1 % 4 == 0) bitv1 = sd1;
            else chk("u1 sd held across bit", {31'd0, sd1}, {31'd0, bitv1});
            chk("u1 sd_en phase", {31'd0, en1}, (fc1 % 4 == 3) ? 32'd1 : 32'd0);
            if (en1) begin
                acc1 = {sd1, acc1[7:1]};
                nb1++;
            end
            if (dn1) begin
                chk("u1 done cycle", fc1, 31);
                chk("u1 strobes per word", nb1, 8);
                if (q1.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL u1 unexpected done: got word %h, expected no done", acc1);
                end else begin
                    chk("u1 word", {24'd0, acc1}, {24'd0, q1.pop_front()});
                end
                nb1 = 0;
            end
            fc1++;
        end else begin
            chk("u1 idle outputs", {30'd0, sd1, en1}, 32'd0);
            if (fc1 != 0) begin
                chk("u1 frame length", fc1, 32);
                fc1 = 0;
            end
        end
    end

    // Receiver loopback on u2: enabled DFF chain captures sd on each strobe.
    logic [7:0] chain = '0;
    always @(posedge clk) if (en2) chain <= {chain[6:0], sd2};

    bit pend2 = 0;
    initial forever begin
        @(negedge clk);
        if (pend2) begin
            pend2 = 0;
            if (q2.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL u2 unexpected done: got chain %h, expected no done", chain);
            end else begin
                chk("u2 loopback chain", {24'd0, chain}, {24'd0, q2.pop_front()});
            end
        end
        if (!reset && dn2) pend2 = 1;
    end

    initial begin
        int a, b, dcb;
        d0 = '0; d1 = '0; d2 = '0;
        lv0 = 0; lv1 = 0; lv2 = 0;

        // Held in reset: everything low, including load_ready.
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs u0", {27'd0, rdy0, sd0, en0, fr0, dn0}, 32'd0);
        chk("reset ready u1/u2", {30'd0, rdy1, rdy2}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("ready before first edge", {31'd0, rdy0}, 32'd0);
        @(negedge clk);
        chk("ready after first edge", {29'd0, rdy0, rdy1, rdy2}, 32'd7);
        chk("idle sd/frame", {30'd0, sd0, fr0}, 32'd0);

        // Asynchronous assertion mid-cycle.
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("async reset ready", {29'd0, rdy0, rdy1, rdy2}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("ready after reset release", {31'd0, rdy0}, 32'd1);

        // Basic MSB-first word.
        send(0, 8'hA5, 1, 0, a);
        wait_empty(0);
        chk("u0 done latency", last_done0 - a, 7);

        // Busy ignore: second word held on the bus during the first frame.
        send(0, 8'hFF, 1, 1, a);
        send(0, 8'h00, 1, 0, b);
        chk("u0 next accept after done", b - last_done0, 2);
        chk("u0 word spacing", b - a, 9);
        wait_empty(0);

        // Reset mid-word: C3 is discarded, 3C follows cleanly.
        dcb = dc0;
        send(0, 8'hC3, 0, 0, a);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("mid-word reset outputs", {27'd0, rdy0, sd0, en0, fr0, dn0}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("no done for aborted word", dc0, dcb);
        send(0, 8'h3C, 1, 0, a);
        wait_empty(0);

        // LSB first, stretched bits.
        send(1, 8'h01, 1, 0, a);
        wait_empty(1);
        send(1, 8'h96, 1, 0, a);
        wait_empty(1);

        // Back-to-back random words into the loopback chain.
        for (int i = 0; i < 5; i++) begin
            send(2, 8'($urandom), 1, (i < 4), a);
        end
        wait_empty(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serializer_tx.md
# serializer_tx

Parallel-to-serial transmitter. It accepts a WIDTH-bit word over a valid/ready handshake and drives it out one bit at a time on a serial data line. Each bit has a one-cycle enable strobe, so a downstream chain of enabled D flip-flops (serial receiver / SIPO) can capture it. It is the transmit end of the team's single-wire, strobe-qualified serial link and sits between a parallel producer and the flip-flop-based receive path.

## Interface
- WIDTH, 8: bits per word; must be ≥1.
- CLKS_PER_BIT, 1: clock cycles each bit is held on sd; must be ≥1.
- MSB_FIRST, 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.

- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- data_in  input  WIDTH  word to send; sampled only on the accepting edge.
- load_valid  input  1  producer offers data_in.
- load_ready  output  1  block can accept a word (IDLE).
- sd  output  1  serial data bit.
- sd_en  output  1  one-cycle strobe marking the capture cycle of the current bit.
- frame  output  1  high while a word is on sd.
- done  output  1  one-cycle pulse on the final bit's strobe cycle.

## Operation
- FSM has two states, IDLE and SHIFT.
- **IDLE:**
  - load_ready=1, sd=0, sd_en=0, frame=0, done=0.
  - On the edge where load_valid && load_ready: latch data_in into the shift register, clear the bit counter and tick counter, and go to SHIFT.
- **SHIFT:**
  - frame=1 and load_ready=0.
  - sd is the current head bit: MSB when MSB_FIRST=1, LSB when MSB_FIRST=0.
  - The tick counter runs 0..CLKS_PER_BIT-1.
  - sd_en=1 only when tick == CLKS_PER_BIT-1. With CLKS_PER_BIT=1, sd_en=1 on every SHIFT cycle.
  - On the edge that ends a strobe cycle, the shift register advances one bit and the bit counter increments.
  - done=1 during the strobe cycle of bit WIDTH-1. The following edge returns the FSM to IDLE.
- load_valid in SHIFT is ignored. Producer must hold load_valid and data_in until load_ready.
- Changes on data_in after acceptance have no effect on the word in flight.
- Counter widths: tick uses $clog2(CLKS_PER_BIT) bits, min 1. Bit counter uses $clog2(WIDTH) bits, min 1. No wrap occurs; the terminal compare ends the word.
- **Reset (async):**
  - Any time reset=1: state=IDLE and every output is 0, including load_ready.
  - A word in flight is discarded with no done pulse.
  - After reset deasserts, load_ready rises on the first rising clk edge.

## Timing
- Acceptance at edge N.
- sd/frame are valid from just after edge N through edge N+WIDTH*CLKS_PER_BIT.
- Bit k (0-based, transmit order) is held during cycles N+k*CLKS_PER_BIT .. N+(k+1)*CLKS_PER_BIT-1.
- The sd_en strobe falls in the last cycle of each bit.
- done coincides with the last sd_en.
- load_ready=1 after edge N+WIDTH*CLKS_PER_BIT. Next acceptance is possible at edge N+WIDTH*CLKS_PER_BIT+1.
- Throughput: one word per WIDTH*CLKS_PER_BIT+1 cycles.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Shared package serial_link_pkg holds:
  - the state enum (IDLE, SHIFT);
  - a clog2-min-1 width constant function, which the future receiver also uses.
- One sub-module: bit_tick_gen, a CLKS_PER_BIT period counter. It takes clear/run and outputs the terminal tick that drives sd_en.
- Shift register, bit counter and FSM stay in serializer_tx.

## Test plan
- **Reset:** assert reset mid-cycle.
  - All outputs must go 0 without waiting for a clk edge.
  - Release reset: load_ready=1 after the first edge; sd=0, frame=0.
- **Basic MSB-first word:** WIDTH=8, CLKS_PER_BIT=1, MSB_FIRST=1, load 8'hA5.
  - sd sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles, with sd_en=1 each cycle.
  - done on the 8th cycle; load_ready back after 8 cycles.
- **LSB-first with bit stretching:** CLKS_PER_BIT=4, MSB_FIRST=0, load 8'h01.
  - sd=1 for the first 4 cycles, then 0 for 28 cycles.
  - sd_en high exactly on cycles 3,7,…,31 after acceptance; frame high 32 cycles.
- **Busy ignore:** load 8'hFF, then present 8'h00 with load_valid held during SHIFT.
  - 8'hFF is sent intact.
  - 8'h00 is accepted exactly one cycle after done; the next frame sends all zeros.
- **Reset mid-word:** assert reset after 3 bits of 8'hC3.
  - Outputs go 0 immediately and no done pulse occurs.
  - After release, a new load of 8'h3C transmits correctly from its first bit.
- **Receiver loopback:** 8 enabled DFFs form a shift chain (d=sd, en=sd_en) fed by back-to-back random words, WIDTH=8, CLKS_PER_BIT=3.
  - The chain contents equal each transmitted word at its done pulse.
